// File: rtl/axi2ahb_wdata.sv
// -----------------------------------------------------------------------------
// axi2ahb_wdata
//
// Write-data path of the AXI-to-AHB bridge. AXI W beats are buffered in a
// small FIFO. The head beat drives HWDATA during each AHB write data phase
// that the bridge controller signals. Errors seen during a burst are collected
// in a sticky flag, and one AXI B response is queued when the burst's last
// beat completes.
//
// Handshakes: a transfer happens on a rising ACLK edge where both valid and
// ready are high. WREADY and BVALID never depend on the other side's valid or
// ready. ctrl_wdata_ready_o is sampled by the controller at the start of a
// data phase. ctrl_wdata_valid_i is then held until HREADY=1, and that
// cycle completes the beat.
//
// Ports:
//   ACLK, ARESET                 clock, synchronous active-high reset
//   WDATA/WSTRB/WLAST/WVALID     AXI W channel in
//   WREADY                       AXI W channel ready out
//   BID/BRESP/BVALID             AXI B channel out
//   BREADY                       AXI B channel ready in
//   HWDATA                       AHB write data (head of W FIFO)
//   HREADY, HRESP                AHB transfer done / error
//   cmd_id_i, cmd_error_i        ID and controller error for the current burst
//   ctrl_wdata_valid_i           AHB write data phase active
//   ctrl_wdata_last_i            current data phase is the burst's last beat
//   ctrl_wdata_ready_o           head beat present and a B slot is free
// -----------------------------------------------------------------------------
module axi2ahb_wdata #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int WDATA_DEPTH    = 4,
    parameter int BRESP_DEPTH    = 2
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                        WLAST,
    input  logic                        WVALID,
    output logic                        WREADY,
    output logic [AXI_ID_WIDTH-1:0]     BID,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    output logic [AXI_DATA_WIDTH-1:0]   HWDATA,
    input  logic                        HREADY,
    input  logic                        HRESP,
    input  logic [AXI_ID_WIDTH-1:0]     cmd_id_i,
    input  logic                        cmd_error_i,
    input  logic                        ctrl_wdata_valid_i,
    input  logic                        ctrl_wdata_last_i,
    output logic                        ctrl_wdata_ready_o
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int WA     = $clog2(WDATA_DEPTH);
    localparam int BA     = $clog2(BRESP_DEPTH);

    localparam logic [WA:0] W_FULL_CNT = (WA+1)'(WDATA_DEPTH);
    localparam logic [BA:0] B_FULL_CNT = (BA+1)'(BRESP_DEPTH);

    // W FIFO storage
    logic [AXI_DATA_WIDTH-1:0] wdata_mem [WDATA_DEPTH];
    logic [STRB_W-1:0]         wstrb_mem [WDATA_DEPTH];
    logic [WDATA_DEPTH-1:0]    wlast_mem;
    logic [WA-1:0]             w_wr_ptr;
    logic [WA-1:0]             w_rd_ptr;
    logic [WA:0]               w_count;

    // B queue storage
    logic [AXI_ID_WIDTH-1:0]   bid_mem   [BRESP_DEPTH];
    logic [1:0]                bresp_mem [BRESP_DEPTH];
    logic [BA-1:0]             b_wr_ptr;
    logic [BA-1:0]             b_rd_ptr;
    logic [BA:0]               b_count;

    logic                      err_acc;

    logic w_full, w_empty, b_full, b_empty;
    logic w_push, w_pop, b_push, b_pop;
    logic beat_done, burst_done, beat_err;
    logic head_strb_bad, head_last_bad;
    logic [1:0] new_bresp;

    assign w_full  = (w_count == W_FULL_CNT);
    assign w_empty = (w_count == '0);
    assign b_full  = (b_count == B_FULL_CNT);
    assign b_empty = (b_count == '0);

    assign WREADY             = !w_full && !ARESET;
    assign ctrl_wdata_ready_o = !w_empty && !b_full;
    assign HWDATA             = wdata_mem[w_rd_ptr];

    assign BVALID = !b_empty;
    assign BID    = bid_mem[b_rd_ptr];
    assign BRESP  = bresp_mem[b_rd_ptr];

    assign w_push     = WVALID && WREADY;
    assign beat_done  = ctrl_wdata_valid_i && HREADY;
    assign burst_done = beat_done && ctrl_wdata_last_i;
    // A data phase against an empty FIFO is a controller bug: no pop, no B entry.
    assign w_pop      = beat_done && !w_empty;
    assign b_push     = burst_done && !w_empty;
    assign b_pop      = BVALID && BREADY;

    // A beat is only acceptable on AHB if all byte lanes are written and the
    // AXI burst framing agrees with the controller's view of the burst.
    assign head_strb_bad = (wstrb_mem[w_rd_ptr] != '1);
    assign head_last_bad = (wlast_mem[w_rd_ptr] != ctrl_wdata_last_i);

    // HRESP counts from its first (HREADY=0) cycle, not only at completion.
    assign beat_err = (ctrl_wdata_valid_i && HRESP) || cmd_error_i ||
                      (beat_done && (head_strb_bad || head_last_bad));

    assign new_bresp = (err_acc || beat_err) ? 2'b10 : 2'b00;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_wr_ptr  <= '0;
            w_rd_ptr  <= '0;
            w_count   <= '0;
            wlast_mem <= '0;
            for (int i = 0; i < WDATA_DEPTH; i++) begin
                wdata_mem[i] <= '0;
                wstrb_mem[i] <= '0;
            end
            b_wr_ptr <= '0;
            b_rd_ptr <= '0;
            b_count  <= '0;
            for (int i = 0; i < BRESP_DEPTH; i++) begin
                bid_mem[i]   <= '0;
                bresp_mem[i] <= '0;
            end
            err_acc <= 1'b0;
        end else begin
            // W FIFO
            if (w_push) begin
                wdata_mem[w_wr_ptr] <= WDATA;
                wstrb_mem[w_wr_ptr] <= WSTRB;
                wlast_mem[w_wr_ptr] <= WLAST;
                w_wr_ptr            <= w_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                w_rd_ptr <= w_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   w_count <= w_count + 1'b1;
                2'b01:   w_count <= w_count - 1'b1;
                default: w_count <= w_count;
            endcase

            // Sticky burst error; the last beat's own error is folded into
            // new_bresp directly, so the flag can clear on that same edge.
            if (burst_done) begin
                err_acc <= 1'b0;
            end else begin
                err_acc <= err_acc || beat_err;
            end

            // B queue
            if (b_push) begin
                bid_mem[b_wr_ptr]   <= cmd_id_i;
                bresp_mem[b_wr_ptr] <= new_bresp;
                b_wr_ptr            <= b_wr_ptr + 1'b1;
            end
            if (b_pop) begin
                b_rd_ptr <= b_rd_ptr + 1'b1;
            end
            case ({b_push, b_pop})
                2'b10:   b_count <= b_count + 1'b1;
                2'b01:   b_count <= b_count - 1'b1;
                default: b_count <= b_count;
            endcase
        end
    end

endmodule

// File: tb/tb_axi2ahb_wdata.sv
module tb_axi2ahb_wdata;

    localparam int IDW = 1;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int WD  = 4;
    localparam int BD  = 2;

    // ---------------- clock / reset ----------------
    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic           ARESET;
    logic [DW-1:0]  WDATA;
    logic [SW-1:0]  WSTRB;
    logic           WLAST, WVALID, WREADY;
    logic [IDW-1:0] BID;
    logic [1:0]     BRESP;
    logic           BVALID, BREADY;
    logic [DW-1:0]  HWDATA;
    logic           HREADY, HRESP;
    logic [IDW-1:0] cmd_id_i;
    logic           cmd_error_i, ctrl_wdata_valid_i, ctrl_wdata_last_i;
    logic           ctrl_wdata_ready_o;

    axi2ahb_wdata #(
        .AXI_ID_WIDTH  (IDW),
        .AXI_DATA_WIDTH(DW),
        .WDATA_DEPTH   (WD),
        .BRESP_DEPTH   (BD)
    ) dut (
        .ACLK              (ACLK),
        .ARESET            (ARESET),
        .WDATA             (WDATA),
        .WSTRB             (WSTRB),
        .WLAST             (WLAST),
        .WVALID            (WVALID),
        .WREADY            (WREADY),
        .BID               (BID),
        .BRESP             (BRESP),
        .BVALID            (BVALID),
        .BREADY            (BREADY),
        .HWDATA            (HWDATA),
        .HREADY            (HREADY),
        .HRESP             (HRESP),
        .cmd_id_i          (cmd_id_i),
        .cmd_error_i       (cmd_error_i),
        .ctrl_wdata_valid_i(ctrl_wdata_valid_i),
        .ctrl_wdata_last_i (ctrl_wdata_last_i),
        .ctrl_wdata_ready_o(ctrl_wdata_ready_o)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Buffered beats {data, strb, last} and expected responses {id, resp}
    logic [DW+SW:0]  wq[$];
    logic [IDW+1:0]  exp_q[$];
    logic            err_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Reference model: updates on every rising edge from the sampled inputs.
    always @(posedge ACLK) begin
        logic           m_push, m_done, m_pop, m_berr;
        logic [DW+SW:0] head;
        if (ARESET) begin
            wq.delete();
            exp_q.delete();
            err_m  = 1'b0;
            chk_en = 1'b1;
        end else begin
            assert (!(ctrl_wdata_valid_i && wq.size() == 0))
                else $error("controller data phase with empty W FIFO");
            m_push = WVALID && (wq.size() < WD);
            m_done = ctrl_wdata_valid_i && HREADY;
            m_pop  = m_done && (wq.size() > 0);
            head   = (wq.size() > 0) ? wq[0] : '0;
            m_berr = (ctrl_wdata_valid_i && HRESP) || cmd_error_i ||
                     (m_pop && ((head[SW:1] != '1) || (head[0] != ctrl_wdata_last_i)));
            if (exp_q.size() > 0 && BREADY) void'(exp_q.pop_front());
            if (m_done && ctrl_wdata_last_i) begin
                if (m_pop) exp_q.push_back({cmd_id_i, (err_m || m_berr) ? 2'b10 : 2'b00});
                err_m = 1'b0;
            end else begin
                err_m = err_m || m_berr;
            end
            if (m_pop)  void'(wq.pop_front());
            if (m_push) wq.push_back({WDATA, WSTRB, WLAST});
        end
    end

    // Compare process: outputs settle after the edge; inputs only move on negedge.
    always @(posedge ACLK) begin
        #1;
        if (chk_en) begin
            chk("wready", WREADY, (wq.size() < WD) && !ARESET);
            chk("ctrl_ready", ctrl_wdata_ready_o, (wq.size() > 0) && (exp_q.size() < BD));
            chk("bvalid", BVALID, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                chk("bid", BID, exp_q[0][IDW+1:2]);
                chk("bresp", BRESP, exp_q[0][1:0]);
            end
            if (wq.size() > 0) begin
                chk("hwdata", HWDATA, wq[0][DW+SW:SW+1]);
            end
        end
    end

    // ---------------- driver tasks (enter and leave on a negedge) ----------------
    task automatic w_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
        int n = 0;
        while (wq.size() >= WD && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 100) timeout_fail("w_beat");
        WVALID = 1'b1;
        WDATA  = d;
        WSTRB  = s;
        WLAST  = l;
        @(negedge ACLK);
        WVALID = 1'b0;
    endtask

    task automatic phase(input logic [IDW-1:0] id, input logic last, input int waits,
                         input logic herr, input logic [DW-1:0] exp_d);
        int n = 0;
        while (!(wq.size() > 0 && exp_q.size() < BD) && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 100) begin
            timeout_fail("phase_start");
            return;
        end
        ctrl_wdata_valid_i = 1'b1;
        cmd_id_i           = id;
        ctrl_wdata_last_i  = last;
        HRESP              = herr;
        for (int i = 0; i <= waits; i++) begin
            HREADY = (i == waits);
            chk("phase_hwdata", HWDATA, exp_d);
            @(negedge ACLK);
        end
        ctrl_wdata_valid_i = 1'b0;
        HREADY             = 1'b1;
        HRESP              = 1'b0;
    endtask

    task automatic expect_b(input logic [IDW-1:0] id, input logic [1:0] resp);
        int n = 0;
        while (!BVALID && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 50) begin
            timeout_fail("expect_b");
            return;
        end
        chk("exp_bid", BID, id);
        chk("exp_bresp", BRESP, resp);
        @(negedge ACLK);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  gen_left;
        bit  in_phase;

        ARESET = 1'b1;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
        cmd_id_i = '0; cmd_error_i = 1'b0;
        ctrl_wdata_valid_i = 1'b0; ctrl_wdata_last_i = 1'b0;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        chk("rst_wready", WREADY, 1);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_bid", BID, 0);
        chk("rst_bresp", BRESP, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_ctrl_ready", ctrl_wdata_ready_o, 0);
        @(negedge ACLK);

        // Single beat
        w_beat(32'hDEADBEEF, 4'hF, 1'b1);
        phase(1'b1, 1'b1, 0, 1'b0, 32'hDEADBEEF);
        chk("single_bvalid", BVALID, 1);
        expect_b(1'b1, 2'b00);

        // 4-beat burst, two wait states on beat 2
        w_beat(32'h1111_0001, 4'hF, 1'b0);
        w_beat(32'h1111_0002, 4'hF, 1'b0);
        w_beat(32'h1111_0003, 4'hF, 1'b0);
        w_beat(32'h1111_0004, 4'hF, 1'b1);
        phase(1'b0, 1'b0, 0, 1'b0, 32'h1111_0001);
        phase(1'b0, 1'b0, 2, 1'b0, 32'h1111_0002);
        phase(1'b0, 1'b0, 0, 1'b0, 32'h1111_0003);
        phase(1'b0, 1'b1, 0, 1'b0, 32'h1111_0004);
        expect_b(1'b0, 2'b00);

        // Two-cycle AHB error on beat 3, then a clean burst
        w_beat(32'h2222_0001, 4'hF, 1'b0);
        w_beat(32'h2222_0002, 4'hF, 1'b0);
        w_beat(32'h2222_0003, 4'hF, 1'b0);
        w_beat(32'h2222_0004, 4'hF, 1'b1);
        phase(1'b1, 1'b0, 0, 1'b0, 32'h2222_0001);
        phase(1'b1, 1'b0, 0, 1'b0, 32'h2222_0002);
        phase(1'b1, 1'b0, 1, 1'b1, 32'h2222_0003);
        phase(1'b1, 1'b1, 0, 1'b0, 32'h2222_0004);
        expect_b(1'b1, 2'b10);
        w_beat(32'h2222_0005, 4'hF, 1'b1);
        phase(1'b0, 1'b1, 0, 1'b0, 32'h2222_0005);
        expect_b(1'b0, 2'b00);

        // B backpressure fills the response queue
        BREADY = 1'b0;
        w_beat(32'h3333_0001, 4'hF, 1'b1);
        w_beat(32'h3333_0002, 4'hF, 1'b1);
        w_beat(32'h3333_0003, 4'hF, 1'b1);
        phase(1'b0, 1'b1, 0, 1'b0, 32'h3333_0001);
        phase(1'b1, 1'b1, 0, 1'b0, 32'h3333_0002);
        chk("bp_ctrl_ready", ctrl_wdata_ready_o, 0);
        chk("bp_bvalid", BVALID, 1);
        BREADY = 1'b1;
        expect_b(1'b0, 2'b00);
        expect_b(1'b1, 2'b00);
        chk("bp_ready_back", ctrl_wdata_ready_o, 1);
        phase(1'b1, 1'b1, 0, 1'b0, 32'h3333_0003);
        expect_b(1'b1, 2'b00);

        // FIFO full, simultaneous push/pop, partial strobe
        w_beat(32'h4444_000A, 4'hF, 1'b0);
        w_beat(32'h4444_000B, 4'h3, 1'b0);
        w_beat(32'h4444_000C, 4'hF, 1'b0);
        w_beat(32'h4444_000D, 4'hF, 1'b1);
        chk("full_wready", WREADY, 0);
        phase(1'b0, 1'b0, 0, 1'b0, 32'h4444_000A);
        WVALID = 1'b1; WDATA = 32'h4444_000E; WSTRB = 4'hF; WLAST = 1'b1;
        ctrl_wdata_valid_i = 1'b1; cmd_id_i = 1'b0; ctrl_wdata_last_i = 1'b0; HREADY = 1'b1;
        chk("simul_hwdata", HWDATA, 32'h4444_000B);
        chk("simul_wready", WREADY, 1);
        @(negedge ACLK);
        WVALID = 1'b0;
        ctrl_wdata_valid_i = 1'b0;
        w_beat(32'h4444_000F, 4'hF, 1'b1);
        chk("refill_wready", WREADY, 0);
        phase(1'b0, 1'b0, 0, 1'b0, 32'h4444_000C);
        phase(1'b0, 1'b1, 0, 1'b0, 32'h4444_000D);
        expect_b(1'b0, 2'b10);
        phase(1'b1, 1'b1, 0, 1'b0, 32'h4444_000E);
        expect_b(1'b1, 2'b00);
        phase(1'b0, 1'b1, 0, 1'b0, 32'h4444_000F);
        expect_b(1'b0, 2'b00);

        // Reset in the middle of a burst
        w_beat(32'h5555_0001, 4'hF, 1'b0);
        w_beat(32'h5555_0002, 4'hF, 1'b0);
        phase(1'b1, 1'b0, 0, 1'b0, 32'h5555_0001);
        ARESET = 1'b1;
        #1;
        chk("rst_mid_wready_low", WREADY, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        chk("rst_mid_wready", WREADY, 1);
        chk("rst_mid_bvalid", BVALID, 0);
        chk("rst_mid_ctrl_ready", ctrl_wdata_ready_o, 0);
        repeat (10) @(negedge ACLK);

        // Randomized traffic
        gen_left = 0;
        in_phase = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (in_phase && HREADY) in_phase = 1'b0;
            if (ARESET) begin
                in_phase = 1'b0;
                gen_left = 0;
            end
            ARESET      = ($urandom_range(0, 399) == 0);
            BREADY      = ($urandom_range(0, 9) < 6);
            cmd_error_i = ($urandom_range(0, 59) == 0);
            if (gen_left == 0) gen_left = $urandom_range(1, 4);
            WVALID = ($urandom_range(0, 2) != 0);
            WDATA  = $urandom;
            WSTRB  = ($urandom_range(0, 9) == 0) ? SW'($urandom) : '1;
            WLAST  = (gen_left == 1);
            if (WVALID && !ARESET && wq.size() < WD) gen_left--;
            if (!in_phase && !ARESET && wq.size() > 0 && exp_q.size() < BD &&
                $urandom_range(0, 3) != 0) begin
                in_phase          = 1'b1;
                cmd_id_i          = IDW'($urandom);
                ctrl_wdata_last_i = wq[0][0] ^ ($urandom_range(0, 15) == 0);
            end
            ctrl_wdata_valid_i = in_phase;
            HREADY = in_phase ? ($urandom_range(0, 9) < 7) : 1'b1;
            HRESP  = in_phase && ($urandom_range(0, 19) == 0);
            @(negedge ACLK);
        end

        // Drain
        ARESET = 1'b0; WVALID = 1'b0; ctrl_wdata_valid_i = 1'b0;
        cmd_error_i = 1'b0; HREADY = 1'b1; HRESP = 1'b0; BREADY = 1'b1;
        repeat (10) @(negedge ACLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
